// File: rtl/nios2_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mul_pkg
// Purpose  : Shared definitions for the Nios II multiply sequencer: the
//            operation encodings, the sequencer state type and the widths
//            of the partial-product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package nios2_mul_pkg;

  // Operation encodings carried on the op port
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
  localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

  // p1 + ((p2 + p3) << 16) needs 50 bits to hold without truncation
  localparam int MID_W  = 50;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ISS1 = 2'd1,
    CMB1 = 2'd2,
    CMB2 = 2'd3
  } mul_state_e;

endpackage : nios2_mul_pkg
`default_nettype wire

// File: rtl/nios2_mul_hi_fix.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mul_hi_fix
// Purpose  : Converts the unsigned high product word into the signed high
//            word. Interpreting a negative operand as unsigned adds 2^32
//            times the other operand, so that operand is removed from the
//            high word for each signed, negative input.
// Ports    : a_i, b_i   - 32-bit operands
//            sa_i, sb_i - operand A / operand B is signed
//            uhi_i      - unsigned high word of a*b
//            hi_o       - corrected high word (modulo 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mul_hi_fix (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sa_i,
  input  logic        sb_i,
  input  logic [31:0] uhi_i,
  output logic [31:0] hi_o
);

  logic [31:0] w_corr_a;
  logic [31:0] w_corr_b;

  assign w_corr_a = (sa_i && a_i[31]) ? b_i : 32'd0;
  assign w_corr_b = (sb_i && b_i[31]) ? a_i : 32'd0;
  assign hi_o     = uhi_i - w_corr_a - w_corr_b;

endmodule : nios2_mul_hi_fix
`default_nettype wire

// File: rtl/nios2_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mul_seq
// Purpose  : Sequences the 16x16 partial-product multiplier cell to produce
//            MUL (low word) in one cell pass and MULXUU/MULXSU/MULXSS
//            (high word) in two cell passes.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            start, op, src1/2   - request; sampled while busy is low
//            busy, done, result  - status, one-cycle done pulse, product
//            cell_src1/2, cell_en- cell operands and register enable
//            cell_p1/p2/p3       - registered cell partial products
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mul_seq
  import nios2_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  // The schedule below assumes products appear one cycle after capture
  if (CELL_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "nios2_mul_seq: only CELL_LATENCY=1 is supported");
  end

  mul_state_e         state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [MID_W-1:0]   mid_q, mid_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;

  logic [32:0]        w_p23;
  logic [MID_W-1:0]   w_mid;
  logic [31:0]        w_uhi;
  logic [31:0]        w_hi;
  logic               w_sa;
  logic               w_sb;

  // Pass-1 products combined into the full 50-bit low/middle sum
  assign w_p23 = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign w_mid = {{(MID_W-32){1'b0}}, cell_p1} + {1'b0, w_p23, {HALF_W{1'b0}}};

  // Pass-2 cell_p1 is aH*bH; add the carry-out of the lower 32 bits
  assign w_uhi = cell_p1 + {{(64-MID_W){1'b0}}, mid_q[MID_W-1:32]};

  assign w_sa = (op_q == MUL_OP_MULXSU) || (op_q == MUL_OP_MULXSS);
  assign w_sb = (op_q == MUL_OP_MULXSS);

  nios2_mul_hi_fix u_hi_fix (
    .a_i   (a_q),
    .b_i   (b_q),
    .sa_i  (w_sa),
    .sb_i  (w_sb),
    .uhi_i (w_uhi),
    .hi_o  (w_hi)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    mid_d     = mid_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy      = 1'b0;
    cell_en   = 1'b0;
    cell_src1 = 32'd0;
    cell_src2 = 32'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          op_d    = op;
          state_d = ISS1;
        end
      end

      ISS1: begin
        busy      = 1'b1;
        cell_en   = 1'b1;
        cell_src1 = a_q;
        cell_src2 = b_q;
        state_d   = CMB1;
      end

      CMB1: begin
        busy  = 1'b1;
        mid_d = w_mid;
        if (op_q == MUL_OP_MUL) begin
          result_d = w_mid[31:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          // Second pass reuses the cell's p1 lane for aH*bH
          cell_en   = 1'b1;
          cell_src1 = {{HALF_W{1'b0}}, a_q[31:HALF_W]};
          cell_src2 = {{HALF_W{1'b0}}, b_q[31:HALF_W]};
          state_d   = CMB2;
        end
      end

      CMB2: begin
        busy     = 1'b1;
        result_d = w_hi;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 2'd0;
      mid_q    <= '0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      mid_q    <= mid_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule : nios2_mul_seq
`default_nettype wire

// File: tb/tb_nios2_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_mul_seq
// Purpose  : Self-checking bench for nios2_mul_seq with a behavioural model
//            of the registered 16x16 partial-product cell and a scoreboard
//            of expected results, due cycles and cell operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_mul_seq;
  import nios2_mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cp1 = 32'd0;
  logic [31:0] cp2 = 32'd0;
  logic [31:0] cp3 = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
    int          nen;
  } exp_t;

  exp_t sb_q[$];

  nios2_mul_seq #(.CELL_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cell_src1 (cell_src1),
    .cell_src2 (cell_src2),
    .cell_en   (cell_en),
    .cell_p1   (cp1),
    .cell_p2   (cp2),
    .cell_p3   (cp3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered partial-product cell
  always @(posedge clk) begin
    if (cell_en) begin
      cp1 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[15:0]};
      cp2 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[31:16]};
      cp3 <= {16'd0, cell_src1[31:16]} * {16'd0, cell_src2[15:0]};
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    xa = (o == MUL_OP_MULXSU || o == MUL_OP_MULXSS) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (o == MUL_OP_MULXSS) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (o == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start for one cycle and records expectations
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r);
    exp_t e;
    e.res = r;
    e.a   = a;
    e.b   = b;
    e.nen = (o == MUL_OP_MUL) ? 1 : 2;
    e.due = cyc + ((o == MUL_OP_MUL) ? 3 : 4);
    sb_q.push_back(e);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high (or after the cycle budget)
  task automatic wait_done();
    exp_t e;
    int   n_en;
    bit   got;
    n_en = 0;
    got  = 1'b0;
    e    = sb_q[0];
    for (int k = 0; k < 12; k++) begin
      if (cell_en) begin
        n_en++;
        if (n_en == 1) begin
          chk("cell_src1_pass1", cell_src1, e.a);
          chk("cell_src2_pass1", cell_src2, e.b);
        end else begin
          chk("cell_src1_pass2", cell_src1, {16'd0, e.a[31:16]});
          chk("cell_src2_pass2", cell_src2, {16'd0, e.b[31:16]});
        end
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      void'(sb_q.pop_front());
      chk("result", result, e.res);
      chk("done_cycle", cyc, e.due);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("cell_en_cycles", n_en, e.nen);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          ndone;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cell_en", {31'd0, cell_en}, 32'd0);
    chk("rst_cell_src1", cell_src1, 32'd0);
    chk("rst_cell_src2", cell_src2, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    issue(MUL_OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done();

    // Start held high while busy with other operands: must be ignored
    @(negedge clk);
    issue(MUL_OP_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    start = 1'b1;
    op    = MUL_OP_MULXSS;
    src1  = 32'hDEAD_BEEF;
    src2  = 32'hCAFE_F00D;
    wait_done();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("ignored_start_no_op", ndone, 0);
    chk("result_held", result, 32'h2345_6780);

    // Back-to-back: each next op issued in the previous done cycle
    ro = MUL_OP_MULXSU;
    ra = 32'h8765_4321;
    rb = 32'h0FED_CBA9;
    issue(ro, ra, rb, ref_mul(ro, ra, rb));
    for (int i = 0; i < 8; i++) begin
      wait_done();
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i < 7) issue(ro, ra, rb, ref_mul(ro, ra, rb));
    end

    // Abort a MULXUU in CMB1 with an asynchronous reset
    @(negedge clk);
    issue(MUL_OP_MUL, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F);
    wait_done();
    @(negedge clk);
    issue(MUL_OP_MULXUU, 32'hAAAA_5555, 32'h1234_FFFF, 32'h0);
    @(negedge clk);
    chk("cmb1_cell_en", {31'd0, cell_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_cell_en", {31'd0, cell_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    issue(MUL_OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nios2_mul_seq
`default_nettype wire

// File: doc/nios2_mul_seq.md
Name: nios2_mul_seq

Overview:
- Multiply sequencer that sits between the execute stage and the Nios II 16x16 partial-product multiplier cell.
- Drives the cell operands and enable, and consumes the three registered 32-bit partial products: p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16], p3 = src1[31:16]*src2[15:0].
- Assembles the results for MUL (low 32 bits) and for MULXUU/MULXSU/MULXSS (high 32 bits) over one or two cell passes.

Parameters:
- CELL_LATENCY, 1, cycles from cell_en capture edge to valid cell_p*. Only value 1 is supported; any other value is a fatal elaboration error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only while busy=0
- op  in  2  00 MUL, 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS
- src1  in  32  operand A; latched on accept
- src2  in  32  operand B; latched on accept
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  32  product word; held until the next done
- cell_src1  out  32  to cell operand A
- cell_src2  out  32  to cell operand B
- cell_en  out  1  cell register enable
- cell_p1  in  32  cell partial product p1
- cell_p2  in  32  cell partial product p2
- cell_p3  in  32  cell partial product p3

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, port named reset.
  - Reset values: state=IDLE, busy=0, done=0, result=0, cell_en=0, cell_src1=0, cell_src2=0, all internal registers 0.
  - Reset asserted mid-operation aborts the operation immediately; no done is produced.
- Accept: in IDLE, start=1 at a rising edge latches a=src1, b=src2 and op; state goes to ISS1. start while busy=1 is ignored (no queueing).
- State machine:
  - IDLE: busy=0, cell_en=0, cell_src*=0.
  - ISS1: busy=1, cell_src1=a, cell_src2=b, cell_en=1.
  - CMB1: busy=1. Cell outputs hold pass-1 products. Register mid = p1 + ((p2 + p3) << 16), 50-bit unsigned, no truncation.
    - op=MUL: result <= mid[31:0]; done <= 1; next state IDLE.
    - op=MULX*: also drive cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1; next state CMB2.
  - CMB2: busy=1. cell_p1 = aH*bH. Compute hi = cell_p1 + mid[49:32] - (sa & a[31] ? b : 0) - (sb & b[31] ? a : 0), modulo 2^32.
    - sa=1 for MULXSU and MULXSS; sb=1 for MULXSS only.
    - result <= hi; done <= 1; next state IDLE.
- Latency, with start sampled in cycle c0:
  - MUL: done=1 in c0+3; busy=1 in c1..c2.
  - MULX*: done=1 in c0+4; busy=1 in c1..c3.
- done is high for exactly one cycle, in which busy=0. A start in the done cycle is accepted, so back-to-back throughput is one op per 3 cycles (MUL) or 4 cycles (MULX*).
- cell_en=0 outside ISS1 and the MULX* CMB1 cycle. The cell therefore holds its products, and the sequencer never samples stale data.
- result changes only on done.
- op encodings are fully decoded; no illegal values exist.

Decomposition:
- Shared package nios2_mul_pkg:
  - op encoding constants MUL_OP_MUL, MUL_OP_MULXUU, MUL_OP_MULXSU, MUL_OP_MULXSS
  - state enum IDLE/ISS1/CMB1/CMB2
  - width constants for the mid accumulator (50) and the half-word (16)
- Optional sub-module nios2_mul_hi_fix: combinational signed correction of the high word (inputs a, b, sa, sb, uhi).
- The cell itself is instantiated by the parent, not by this block.

Test Plan:
- MUL a=0x00010003, b=0x00020005 -> done at c0+3, result=0x000B000F; cell_en high exactly one cycle.
- MULXUU a=b=0xFFFFFFFF -> done at c0+4, result=0xFFFFFFFE; cell_en high two consecutive cycles.
- MULXSS a=b=0xFFFFFFFF -> result=0x00000000. Also MULXSS a=0x80000000, b=0x80000000 -> result=0x40000000.
- MULXSU a=0xFFFFFFFF, b=0x00000002 -> result=0xFFFFFFFF. Also MULXSU a=0x00000002, b=0xFFFFFFFF -> result=0x00000001.
- start pulsed during busy with different operands -> ignored; the first op's result is unchanged. A new start in the done cycle -> accepted, and its done arrives 3 or 4 cycles later.
- reset asserted in CMB1 of a MULXUU -> busy, done, result and cell_en go to 0 asynchronously; no done pulse after release; next MUL completes correctly.
